cic_interp: RTL and testbench

CIC_INTERP -- requirements
Module: cic_interp

---
 rtl/cic_pkg.sv | 18 +
 rtl/cic_interp_integ.sv | 27 ++
 rtl/cic_interp.sv | 133 +++++++++++++
 tb/tb_cic_interp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and FSM encoding for the CIC interpolator.
// Bit growth per stage covers the largest ratio, R = 2**MAX_OS_SEL.
package cic_pkg;

  localparam int N_DEF      = 3;
  localparam int MAX_OS_SEL = 7;
  localparam int GROWTH     = MAX_OS_SEL;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cic_width(input int dw, input int n);
    return dw + n * GROWTH;
  endfunction

endpackage

// File: rtl/cic_interp_integ.sv
// Registered W-bit wrap-around accumulator with enable.
// One instance per integrator stage of the CIC interpolator.
module cic_interp_integ #(
  parameter int W = 37
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic signed [W-1:0] din_i,
  output logic signed [W-1:0] acc_o
);

  logic signed [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en_i) acc_d = acc_q + din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: N combs at the low rate, zero-stuff, N integrators.
// Define CIC_INTERP_ROUND_EN for round-half-up output scaling.
import cic_pkg::*;

module cic_interp #(
  parameter int DW = 16,
  parameter int N  = N_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    os_sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  output logic [DW-1:0] data_out,
  output logic          underrun
);

  localparam int W  = cic_width(DW, N);
  localparam int VW = $clog2(N + 1);

  state_t        state_q, state_d;
  logic [6:0]    phase_q, phase_d;
  logic [6:0]    last;
  logic [2:0]    rsel_q, rsel_d;
  logic          underrun_q, underrun_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          accept, slot, run;

  logic signed [W-1:0] c     [N+1];
  logic signed [W-1:0] dly_q [N];
  logic signed [W-1:0] acc   [N+1];
  logic signed [W-1:0] u_q, u_d;
  logic signed [W-1:0] biased;
  int                  sh;

  assign run      = (state_q == RUN);
  assign last     = 7'((8'd1 << rsel_q) - 8'd1);
  assign in_ready = !run || (phase_q == last);
  assign accept   = in_valid && in_ready;
  assign slot     = accept || (run && (phase_q == last));

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rsel_d     = rsel_q;
    underrun_d = underrun_q;
    vcnt_d     = vcnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          phase_d = '0;
          rsel_d  = os_sel;
        end
      end
      RUN: begin
        phase_d = (phase_q == last) ? '0 : phase_q + 7'd1;
        if (slot && !accept) underrun_d = 1'b1;
        if (vcnt_q != VW'(N)) vcnt_d = vcnt_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      rsel_q     <= '0;
      underrun_q <= 1'b0;
      vcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rsel_q     <= rsel_d;
      underrun_q <= underrun_d;
      vcnt_q     <= vcnt_d;
    end
  end

  // A missed slot feeds zero so the comb history stays aligned.
  always_comb begin
    c[0] = accept ? W'($signed(data_in)) : '0;
    for (int k = 0; k < N; k++) begin
      c[k+1] = c[k] - dly_q[k];
    end
  end

  assign u_d = slot ? c[N] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) dly_q[k] <= '0;
      u_q <= '0;
    end else begin
      if (slot) begin
        for (int k = 0; k < N; k++) dly_q[k] <= c[k];
      end
      u_q <= u_d;
    end
  end

  assign acc[0] = u_q;

  for (genvar k = 0; k < N; k++) begin : g_integ
    cic_interp_integ #(
      .W(W)
    ) u_integ (
      .clk_i (clk),
      .rst_ni(reset_n),
      .en_i  (run),
      .din_i (acc[k]),
      .acc_o (acc[k+1])
    );
  end

  // Gain is R**(N-1); shifting it out gives unity DC gain.
  always_comb begin
    sh = (N - 1) * int'(rsel_q);
`ifdef CIC_INTERP_ROUND_EN
    if (sh != 0) biased = acc[N] + (W'(1) << (sh - 1));
    else         biased = acc[N];
`else
    biased = acc[N];
`endif
    data_out = DW'(biased >>> sh);
  end

  assign out_valid = (vcnt_q == VW'(N));
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_cic_interp.sv
// Randomized scoreboard bench for cic_interp.
// Reference: zero-stuffed input convolved with boxcar(R)^N, then scaled.
module tb_cic_interp;

  localparam int DW = 16;
  localparam int N  = 3;
`ifdef CIC_INTERP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    os_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic [DW-1:0] data_out;
  logic          underrun;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] sb [$];
  longint             hist [$];
  longint             h [$];
  longint             vals [$];
  bit                 und_exp;

  cic_interp #(
    .DW(DW),
    .N (N)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .os_sel   (os_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .data_out (data_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Impulse response of the whole interpolator at the high rate.
  task automatic build_h(input int r);
    longint t [$];
    h.delete();
    h.push_back(1);
    repeat (N) begin
      t.delete();
      for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
      foreach (h[i]) begin
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      end
      h = t;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_valid: got out_valid=1 expected no pending sample");
      end else begin
        chk("data_out", $signed(data_out), sb.pop_front());
      end
    end
  end

  task automatic run_stream(input int os, input int nsl, input int miss);
    int r;
    int sh;
    r  = 1 << os;
    sh = (N - 1) * os;
    build_h(r);
    hist.delete();
    und_exp = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ready", in_ready, 1);
      chk("idle_valid", out_valid, 0);
      in_valid = 1'b0;
      os_sel   = 3'($urandom);
    end
    for (int s = 0; s < nsl * r; s++) begin
      longint v;
      longint o;
      longint e;
      bit     slot;
      int     j;
      v    = 0;
      o    = 0;
      slot = (s % r == 0);
      j    = s / r;
      @(posedge clk); #1;
      chk("in_ready", in_ready, slot);
      chk("underrun", underrun, und_exp);
      os_sel = (s == 0) ? 3'(os) : 3'($urandom);
      if (slot && j != miss) begin
        in_valid = 1'b1;
        data_in  = 16'(vals[j]);
        v        = vals[j];
      end else if (slot) begin
        in_valid = 1'b0;
        data_in  = 16'($urandom);
        und_exp  = 1'b1;
      end else begin
        in_valid = ($urandom_range(0, 3) == 0);
        data_in  = 16'($urandom);
      end
      hist.push_back(v);
      for (int k = 0; k < h.size() && k < hist.size(); k++)
        o += h[k] * hist[hist.size() - 1 - k];
      e = o;
      if (RND && sh > 0) e += longint'(1) <<< (sh - 1);
      e = e >>> sh;
      sb.push_back(16'(e));
    end
  endtask

  task automatic mid_reset(input bit do_final, input longint fin);
    @(posedge clk);
    @(negedge clk); #1;
    chk("pending", sb.size(), N);
    if (do_final) begin
      chk("final_out", $signed(data_out), fin);
      chk("final_underrun", underrun, 0);
    end
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out", data_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_underrun", underrun, 0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic fill_rand(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++)
      vals.push_back(longint'($urandom_range(0, hi - lo)) + lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    os_sel   = 3'd0;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", data_out, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_underrun", underrun, 0);
    @(negedge clk);
    reset_n = 1'b1;

    vals = '{5, -7, 32767};
    fill_rand(5, -32768, 32767);
    run_stream(0, 8, -1);
    mid_reset(1'b0, 0);

    vals = '{1024, 0, 0, 0, 0, 0};
    run_stream(1, 6, -1);
    mid_reset(1'b1, 0);

    vals = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    run_stream(2, 8, -1);
    mid_reset(1'b1, 1000);

    vals.delete();
    fill_rand(5, -20000, 20000);
    run_stream(3, 5, 2);
    mid_reset(1'b0, 0);

    vals.delete();
    fill_rand(6, -32768, 32767);
    run_stream(2, 6, -1);
    mid_reset(1'b0, 0);
    vals = '{1024, 0, 0, 0, 0, 0};
    run_stream(1, 6, -1);
    mid_reset(1'b1, 0);

    vals = '{1, 0, 0, 0};
    run_stream(1, 4, -1);
    mid_reset(1'b1, 0);

    repeat (6) begin
      int os;
      int miss;
      os   = $urandom_range(0, 4);
      miss = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : -1;
      vals.delete();
      fill_rand(6, -32768, 32767);
      run_stream(os, 6, miss);
      mid_reset(1'b0, 0);
    end

    vals.delete();
    fill_rand(3, -1000, 1000);
    run_stream(7, 3, -1);
    mid_reset(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
